// File: rtl/bb_lcd_rx_pkg.sv
// ============================================================================
// Module  : bb_lcd_rx_pkg
// Brief   : Shared constants for the bit-banged LCD receiver: 7-segment codes
//           for digits 0-9, the undecodable BCD code and parameter defaults.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bb_lcd_rx_pkg;

  // Segment bit order: bit0 top, bit1 upper-right, bit2 lower-right,
  // bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;

  localparam logic [3:0] BCD_ERR = 4'hF;

  localparam int SETTLE_DEFAULT  = 4;
  localparam int TIMEOUT_DEFAULT = 50000;

endpackage

`default_nettype wire

// File: rtl/bb_seg7_to_bcd.sv
// ============================================================================
// Module  : bb_seg7_to_bcd
// Brief   : Combinational 7-segment pattern to BCD decoder. Patterns outside
//           the 0-9 table give 4'hF and raise err_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_seg7_to_bcd
  import bb_lcd_rx_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  // Table lookup; anything not an exact digit pattern is an error
  always_comb begin
    bcd_o = BCD_ERR;
    err_o = 1'b0;
    case (seg_i)
      SEG_CODE_0: bcd_o = 4'd0;
      SEG_CODE_1: bcd_o = 4'd1;
      SEG_CODE_2: bcd_o = 4'd2;
      SEG_CODE_3: bcd_o = 4'd3;
      SEG_CODE_4: bcd_o = 4'd4;
      SEG_CODE_5: bcd_o = 4'd5;
      SEG_CODE_6: bcd_o = 4'd6;
      SEG_CODE_7: bcd_o = 4'd7;
      SEG_CODE_8: bcd_o = 4'd8;
      SEG_CODE_9: bcd_o = 4'd9;
      default:    err_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bb_lcd_rx.sv
// ============================================================================
// Module  : bb_lcd_rx
// Brief   : Receives a 4-digit AC-driven 7-segment LCD (common + segment
//           lines), samples each phase after a settle delay, and decodes a
//           frame of lo/hi phase samples into BCD digits.
//           Optional watchdog on lcdcom: define BB_LCD_RX_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_lcd_rx
  import bb_lcd_rx_pkg::*;
#(
  parameter int SETTLE  = SETTLE_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       lcdcom,
  input  logic [6:0] lcdseg1,
  input  logic [6:0] lcdseg2,
  input  logic [6:0] lcdseg3,
  input  logic [6:0] lcdseg4,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       valid,
  output logic [3:0] seg_err,
  output logic       ac_err,
  output logic       com_lost
);

  if (SETTLE < 1 || SETTLE > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("bb_lcd_rx: SETTLE or TIMEOUT out of legal range");
  end

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  logic [28:0] sync1_q, sync2_q;
  logic        com_prev_q;
  logic        com_s;
  logic [27:0] seg_s;
  logic        com_edge;

  // Two-flop synchronizer on all inputs, plus a delayed com for edge detect
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      com_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {lcdcom, lcdseg4, lcdseg3, lcdseg2, lcdseg1};
      sync2_q    <= sync1_q;
      com_prev_q <= sync2_q[28];
    end
  end

  assign com_s    = sync2_q[28];
  assign seg_s    = sync2_q[27:0];
  assign com_edge = com_s ^ com_prev_q;

  // Settle counter: every com edge (re)arms it, a glitch simply re-arms
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       sample;

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    sample = 1'b0;
    if (com_edge) begin
      cnt_d  = SETTLE_LD;
      pend_d = 1'b1;
    end else if (pend_q) begin
      if (cnt_q == 8'd1) begin
        cnt_d  = 8'd0;
        pend_d = 1'b0;
        sample = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // Settle counter state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= 8'd0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  logic lost;

`ifdef BB_LCD_RX_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);
  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (com_edge)                wd_d = 16'd0;
    else if (wd_q != TIMEOUT_LD) wd_d = wd_q + 16'd1;
  end

  // Watchdog: counts edge-free cycles, saturating at TIMEOUT
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wd_q <= 16'd0;
    else       wd_q <= wd_d;
  end

  assign lost = (wd_q == TIMEOUT_LD);
`else
  assign lost = 1'b0;
`endif

  assign com_lost = lost;

  // On-vector: a segment is on when its line is the inverse of com
  logic [27:0] on_vec, lo_q, lo_d, eff;
  logic        have_lo_q, have_lo_d;
  logic        frame;

  assign on_vec = seg_s ^ {28{com_s}};
  assign eff    = lo_q & on_vec;

  always_comb begin
    lo_d      = lo_q;
    have_lo_d = have_lo_q;
    frame     = 1'b0;
    if (lost) begin
      have_lo_d = 1'b0;
    end else if (sample) begin
      if (!com_s) begin
        lo_d      = on_vec;
        have_lo_d = 1'b1;
      end else begin
        frame     = have_lo_q;
        have_lo_d = 1'b0;
      end
    end
  end

  // Phase history: lo on-vector and whether the last sample was a lo
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lo_q      <= '0;
      have_lo_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      have_lo_q <= have_lo_d;
    end
  end

  logic [15:0] dec_bcd;
  logic [3:0]  dec_err;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bb_seg7_to_bcd u_dec (
      .seg_i (eff[7*g +: 7]),
      .bcd_o (dec_bcd[4*g +: 4]),
      .err_o (dec_err[g])
    );
  end

  logic [15:0] digits_q;
  logic [3:0]  seg_err_q;
  logic        ac_err_q, valid_q;

  // Capture decoded frame results; they hold until the next completed frame
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      digits_q  <= '0;
      seg_err_q <= '0;
      ac_err_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= frame;
      if (frame) begin
        digits_q  <= dec_bcd;
        seg_err_q <= dec_err;
        ac_err_q  <= |(lo_q ^ on_vec);
      end
    end
  end

  assign digit1  = digits_q[3:0];
  assign digit2  = digits_q[7:4];
  assign digit3  = digits_q[11:8];
  assign digit4  = digits_q[15:12];
  assign seg_err = seg_err_q;
  assign ac_err  = ac_err_q;
  assign valid   = valid_q;

endmodule

`default_nettype wire

// File: doc/bb_lcd_rx.md
BB_LCD_RX -- requirements
Module: bb_lcd_rx

Interface
REQ-001 SETTLE, default 4, clk cycles from a synchronized lcdcom edge to the segment sample (legal 1..255).
REQ-002 TIMEOUT, default 50000, clk cycles without a lcdcom edge before com_lost asserts (legal 2..65535).
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 lcdcom  in  1  LCD common electrode, AC square wave, asynchronous to clk.
REQ-006 lcdseg1..lcdseg4  in  7 each  AC-driven segment lines; segment on = line inverse of lcdcom; bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
REQ-007 digit1..digit4  out  4 each  decoded BCD per digit; 4'hF = undecodable.
REQ-008 valid  out  1  one-cycle pulse; digit*, seg_err and ac_err updated this cycle.
REQ-009 seg_err  out  4  bit k-1 = digit k pattern not in the 0-9 table.
REQ-010 ac_err  out  1  some segment was not driven opposite to lcdcom in both phases of the last frame.
REQ-011 com_lost  out  1  no lcdcom edge for TIMEOUT cycles.

Function
REQ-012 All 29 inputs SHALL pass a 2-flop synchronizer; the remaining logic uses only synchronized values.
REQ-013 Any edge of synchronized lcdcom SHALL load a settle counter with SETTLE; the sample is taken when the counter reaches 0.
REQ-014 An edge arriving while the counter is nonzero SHALL reload it and discard the pending sample (glitch rejection).
REQ-015 At sample, on-vector per digit = seg XOR {7{com}}, stored in the phase register lo (com=0) or hi (com=1).
REQ-016 A frame completes on a hi sample whose preceding sample was lo; lo-lo or hi-hi sequences overwrite and do not complete a frame.
REQ-017 Effective segments per digit = on_lo AND on_hi; ac_err = OR over all digits of (on_lo XOR on_hi).
REQ-018 Decode table: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9; any other pattern gives 4'hF and sets the seg_err bit.
REQ-019 digit*, seg_err and ac_err SHALL register, and valid SHALL pulse, exactly SETTLE+1 cycles after the cycle the completing synchronized edge is detected; outputs hold between frames.
REQ-020 Watchdog counter increments each cycle without an edge, saturates at TIMEOUT, and clears on any edge.
REQ-021 com_lost SHALL assert in the cycle the counter reaches TIMEOUT and deassert in the cycle after the next edge.
REQ-022 While com_lost=1: valid is suppressed and the lo/hi history is cleared; after recovery a fresh lo then hi pair is required before the next valid.

Reset
REQ-023 nrst low SHALL immediately clear synchronizers, counters, phase registers, digit*=0, valid=0, seg_err=0, ac_err=0 and com_lost=0, including mid-frame.
REQ-024 After nrst rises, the first frame requires a full lo then hi sample pair; there are no stale valids.

Configuration
REQ-025 Macro BB_LCD_RX_WATCHDOG_EN defined: REQ-020..022 are implemented.
REQ-026 BB_LCD_RX_WATCHDOG_EN undefined: no watchdog counter, com_lost is tied to 0, and REQ-022 does not apply.

Structure
REQ-027 A shared package holds the ten segment-code constants, the 4'hF error code, and the default SETTLE/TIMEOUT values.
REQ-028 Sub-module BB_SEG7_TO_BCD is a combinational 7-bit to 4-bit decoder with an error flag, instantiated four times.

Verification
REQ-029 lcdcom period 200 clk; segments carry codes 3,4,5,6 XOR com -> after the first lo/hi pair, valid pulses; digits 3,4,5,6; seg_err=0; ac_err=0.
REQ-030 lcdseg1 held at 0x00 while com toggles -> ac_err=1, digit1=F, seg_err=4'b0001.
REQ-031 Digit2 pattern 0x79 driven correctly -> digit2=F, seg_err=4'b0010, ac_err=0.
REQ-032 TIMEOUT=100, com stops -> com_lost=1 at idle cycle 100 with no valid; com resumes -> com_lost clears one cycle after the first edge, and valid returns only after a new lo then hi pair.
REQ-033 A com pulse of 2 cycles with SETTLE=4 -> no sample taken, no valid, outputs unchanged.
REQ-034 nrst pulsed low mid-frame -> all outputs are 0 during reset; the first valid after release follows a full lo then hi pair.
